// File: rtl/tx_frame_engine_if.sv
// ---------------------------------------------------------------------------
// tx_frame_engine_if
//   Bundles the load/configuration inputs and the serial/status outputs of
//   the asynchronous serial transmitter frame engine.
//
//   Signals (direction as seen by the engine, i.e. the slave modport):
//     i_load       in   one-cycle strobe offering i_load_data + configuration
//     i_load_data  in   character to send, LSB first            [DATA_W]
//     i_len        in   data bits per frame (clamped 5..DATA_W)  [4]
//     i_pen        in   parity enable
//     i_pmode      in   parity mode: 00 even, 01 odd, 10 mark, 11 space
//     i_stop2      in   1 = two stop bits, 0 = one
//     i_baud_div   in   clocks per bit (values below 2 act as 2) [BAUD_W]
//     i_clr_ovr    in   clears the sticky overrun flag
//     o_tx         out  serial line, idle high
//     o_txrdy      out  holding buffer empty, a load will be accepted
//     o_busy       out  frame in progress
//     o_done       out  one-cycle pulse at the end of each frame
//     o_ovr        out  sticky overrun flag
// ---------------------------------------------------------------------------
interface tx_frame_engine_if #(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 16
);
    logic              i_load;
    logic [DATA_W-1:0] i_load_data;
    logic [3:0]        i_len;
    logic              i_pen;
    logic [1:0]        i_pmode;
    logic              i_stop2;
    logic [BAUD_W-1:0] i_baud_div;
    logic              i_clr_ovr;
    logic              o_tx;
    logic              o_txrdy;
    logic              o_busy;
    logic              o_done;
    logic              o_ovr;

    // Producer side: offers characters and configuration, watches status.
    modport master (
        output i_load, i_load_data, i_len, i_pen, i_pmode, i_stop2,
               i_baud_div, i_clr_ovr,
        input  o_tx, o_txrdy, o_busy, o_done, o_ovr
    );

    // Engine side.
    modport slave (
        input  i_load, i_load_data, i_len, i_pen, i_pmode, i_stop2,
               i_baud_div, i_clr_ovr,
        output o_tx, o_txrdy, o_busy, o_done, o_ovr
    );
endinterface

// File: rtl/tx_frame_engine.sv
// ---------------------------------------------------------------------------
// tx_frame_engine
//   Asynchronous serial transmitter: start bit, 5..DATA_W data bits LSB
//   first, optional parity bit, one or two stop bits. Every bit lasts
//   exactly baud_div clocks. A one-entry holding buffer lets the next
//   character be queued while a frame is on the line, so consecutive frames
//   follow each other with no idle gap.
//
//   Ports:
//     i_clk    sole clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      tx_frame_engine_if.slave (load/config in, tx/status out)
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module tx_frame_engine #(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    tx_frame_engine_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Data length is limited to 5..DATA_W at capture time.
    function automatic logic [3:0] f_clamp_len(input logic [3:0] len);
        logic [3:0] v;
        if (len < 4'd5) begin
            v = 4'd5;
        end else if (int'(len) > DATA_W) begin
            v = 4'(DATA_W);
        end else begin
            v = len;
        end
        return v;
    endfunction

    // A bit time shorter than two clocks is stretched to two.
    function automatic logic [BAUD_W-1:0] f_clamp_div(input logic [BAUD_W-1:0] div);
        logic [BAUD_W-1:0] v;
        if (div < BAUD_W'(2'd2)) begin
            v = BAUD_W'(2'd2);
        end else begin
            v = div;
        end
        return v;
    endfunction

    // Parity over the low 'len' data bits only; mark/space ignore the data.
    function automatic logic f_parity(input logic [DATA_W-1:0] d,
                                      input logic [3:0]        len,
                                      input logic [1:0]        mode);
        logic x;
        logic p;
        x = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            x = x ^ (d[i] & (i < int'(len)));
        end
        case (mode)
            2'b00:   p = x;
            2'b01:   p = ~x;
            2'b10:   p = 1'b1;
            2'b11:   p = 1'b0;
            default: p = x;
        endcase
        return p;
    endfunction

    // Holding buffer (parity is resolved at capture, so pmode need not be kept)
    logic [DATA_W-1:0] r_buf_data;
    logic [3:0]        r_buf_len;
    logic              r_buf_pen;
    logic              r_buf_stop2;
    logic              r_buf_par;
    logic [BAUD_W-1:0] r_buf_div;

    // Frame in progress
    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_len;
    logic              r_pen;
    logic              r_stop2;
    logic              r_par;
    logic [BAUD_W-1:0] r_div;
    logic [BAUD_W-1:0] r_cnt;
    logic [3:0]        r_bit_cnt;
    logic              r_stop_cnt;

    // Registered outputs
    logic              r_tx;
    logic              r_txrdy;
    logic              r_busy;
    logic              r_done;
    logic              r_ovr;

    logic              w_buf_full;
    logic              w_bit_end;
    logic              w_frame_end;
    logic              w_take;
    logic              w_accept;
    logic              w_overrun;
    logic [3:0]        w_len_clamped;
    logic [BAUD_W-1:0] w_reload;

    // txrdy is the exact complement of buffer occupancy.
    assign w_buf_full    = ~r_txrdy;
    assign w_bit_end     = (r_cnt == {BAUD_W{1'b0}});
    assign w_frame_end   = (r_state == ST_STOP) && w_bit_end && !r_stop_cnt;
    // The buffer drains either from idle or on the very edge the last stop
    // bit ends, which is what makes back-to-back frames gapless.
    assign w_take        = w_buf_full && ((r_state == ST_IDLE) || w_frame_end);
    // On a drain edge txrdy is still low, so a load there is an overrun.
    assign w_accept      = bus.i_load && r_txrdy;
    assign w_overrun     = bus.i_load && !r_txrdy;
    assign w_len_clamped = f_clamp_len(bus.i_len);
    assign w_reload      = r_div - BAUD_W'(1'b1);

    assign bus.o_tx    = r_tx;
    assign bus.o_txrdy = r_txrdy;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_ovr   = r_ovr;

    // Holding buffer capture, txrdy handshake and sticky overrun flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txrdy     <= 1'b1;
            r_ovr       <= 1'b0;
            r_buf_data  <= {DATA_W{1'b0}};
            r_buf_len   <= 4'd0;
            r_buf_pen   <= 1'b0;
            r_buf_stop2 <= 1'b0;
            r_buf_par   <= 1'b0;
            r_buf_div   <= {BAUD_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_buf_data  <= bus.i_load_data;
                r_buf_len   <= w_len_clamped;
                r_buf_pen   <= bus.i_pen;
                r_buf_stop2 <= bus.i_stop2;
                r_buf_par   <= f_parity(bus.i_load_data, w_len_clamped, bus.i_pmode);
                r_buf_div   <= f_clamp_div(bus.i_baud_div);
                r_txrdy     <= 1'b0;
            end else if (w_take) begin
                r_txrdy     <= 1'b1;
            end else begin
                r_txrdy     <= r_txrdy;
            end

            // Setting wins over clearing on the same edge.
            if (w_overrun) begin
                r_ovr <= 1'b1;
            end else if (bus.i_clr_ovr) begin
                r_ovr <= 1'b0;
            end else begin
                r_ovr <= r_ovr;
            end
        end
    end

    // Frame sequencer: bit timing, shifting, parity/stop insertion, status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= {DATA_W{1'b0}};
            r_len      <= 4'd0;
            r_pen      <= 1'b0;
            r_stop2    <= 1'b0;
            r_par      <= 1'b0;
            r_div      <= {BAUD_W{1'b0}};
            r_cnt      <= {BAUD_W{1'b0}};
            r_bit_cnt  <= 4'd0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_take) begin
                // Snapshot the buffer so later input changes cannot disturb
                // this frame; start bit goes out immediately.
                r_state    <= ST_START;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
                r_shift    <= r_buf_data;
                r_len      <= r_buf_len;
                r_pen      <= r_buf_pen;
                r_stop2    <= r_buf_stop2;
                r_par      <= r_buf_par;
                r_div      <= r_buf_div;
                r_cnt      <= r_buf_div - BAUD_W'(1'b1);
                r_bit_cnt  <= 4'd0;
                r_stop_cnt <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_state   <= ST_DATA;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                            r_bit_cnt <= r_len - 4'd1;
                            r_cnt     <= w_reload;
                        end else begin
                            r_cnt <= r_cnt - BAUD_W'(1'b1);
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            r_cnt <= w_reload;
                            // r_bit_cnt counts data bits still to send after
                            // the one currently on the line.
                            if (r_bit_cnt != 4'd0) begin
                                r_tx      <= r_shift[0];
                                r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                            end else if (r_pen) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state    <= ST_STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= r_stop2;
                            end
                        end else begin
                            r_cnt <= r_cnt - BAUD_W'(1'b1);
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= ST_STOP;
                            r_tx       <= 1'b1;
                            r_stop_cnt <= r_stop2;
                            r_cnt      <= w_reload;
                        end else begin
                            r_cnt <= r_cnt - BAUD_W'(1'b1);
                        end
                    end
                    ST_STOP: begin
                        if (w_bit_end) begin
                            // r_stop_cnt set means a second stop bit follows.
                            if (r_stop_cnt) begin
                                r_stop_cnt <= 1'b0;
                                r_cnt      <= w_reload;
                            end else begin
                                r_state <= ST_IDLE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt - BAUD_W'(1'b1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_engine.sv
module tb_tx_frame_engine;
    localparam int DATA_W = 8;
    localparam int BAUD_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tx_frame_engine_if #(.DATA_W(DATA_W), .BAUD_W(BAUD_W)) bus ();

    tx_frame_engine #(.DATA_W(DATA_W), .BAUD_W(BAUD_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  len;
        bit          pen;
        logic [1:0]  pm;
        bit          st2;
        logic [15:0] div;
    } cfg_t;

    // Expected line behaviour, one entry per clock
    bit exp_tx[$];
    bit exp_done[$];
    bit exp_busy[$];

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.d   = 8'($urandom);
        c.len = 4'($urandom_range(0, 15));
        c.pen = 1'($urandom);
        c.pm  = 2'($urandom);
        c.st2 = 1'($urandom);
        c.div = 16'($urandom_range(0, 5));
        return c;
    endfunction

    function automatic cfg_t mk_cfg(input logic [7:0] d, input logic [3:0] len,
                                    input bit pen, input logic [1:0] pm,
                                    input bit st2, input logic [15:0] div);
        cfg_t c;
        c.d = d; c.len = len; c.pen = pen; c.pm = pm; c.st2 = st2; c.div = div;
        return c;
    endfunction

    // Reference frame: list of bits from the framing rules, each repeated
    // for one bit time.
    function automatic void model_frame(input cfg_t c, input bit first_done);
        int   l;
        int   dv;
        int   ones;
        bit   bits[$];
        logic [7:0] m;
        l  = (c.len < 4'd5) ? 5 : ((int'(c.len) > DATA_W) ? DATA_W : int'(c.len));
        dv = (c.div < 16'd2) ? 2 : int'(c.div);
        m  = 8'((1 << l) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < l; i++) bits.push_back(c.d[i]);
        if (c.pen) begin
            ones = $countones(c.d & m);
            case (c.pm)
                2'd0:    bits.push_back(ones % 2 == 1);
                2'd1:    bits.push_back(ones % 2 == 0);
                2'd2:    bits.push_back(1'b1);
                default: bits.push_back(1'b0);
            endcase
        end
        bits.push_back(1'b1);
        if (c.st2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < dv; k++) begin
                exp_tx.push_back(bits[b]);
                exp_busy.push_back(1'b1);
                exp_done.push_back(first_done && b == 0 && k == 0);
            end
        end
    endfunction

    function automatic void model_idle_tail();
        exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
        exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
    endfunction

    task automatic drive_cfg(input cfg_t c);
        bus.i_load_data = c.d;
        bus.i_len       = c.len;
        bus.i_pen       = c.pen;
        bus.i_pmode     = c.pm;
        bus.i_stop2     = c.st2;
        bus.i_baud_div  = c.div;
    endtask

    task automatic test_reset();
        bus.i_load = 1'b0; bus.i_clr_ovr = 1'b0;
        drive_cfg(mk_cfg(8'h00, 4'd8, 1'b0, 2'd0, 1'b0, 16'd4));
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", bus.o_tx); end
        checks++; if (bus.o_txrdy !== 1'b1) begin errors++; $display("FAIL reset_txrdy: got %b want 1", bus.o_txrdy); end
        checks++; if (bus.o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        checks++; if (bus.o_ovr !== 1'b0)   begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.o_ovr); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_txrdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tx=%b busy=%b txrdy=%b want 1 0 1", bus.o_tx, bus.o_busy, bus.o_txrdy);
        end
    endtask

    // One isolated frame; inputs are scrambled every cycle after capture.
    task automatic test_frame(input string name, input cfg_t c, input int exp_len);
        int n;
        int busy_cnt;
        bit t, d, b;
        exp_tx.delete(); exp_done.delete(); exp_busy.delete();
        model_frame(c, 1'b0);
        model_idle_tail();
        n = exp_tx.size();
        busy_cnt = 0;
        @(posedge clk); #1;
        drive_cfg(c); bus.i_load = 1'b1;
        @(posedge clk); #1;
        bus.i_load = 1'b0; drive_cfg(rand_cfg());
        @(negedge clk);
        checks++;
        if (bus.o_txrdy !== 1'b0 || bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_capture: txrdy=%b tx=%b busy=%b want 0 1 0", name, bus.o_txrdy, bus.o_tx, bus.o_busy);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t = exp_tx.pop_front(); d = exp_done.pop_front(); b = exp_busy.pop_front();
            checks++;
            if (bus.o_tx !== t || bus.o_done !== d || bus.o_busy !== b) begin
                errors++;
                $display("FAIL %s_cycle%0d: tx=%b done=%b busy=%b want %b %b %b",
                         name, i, bus.o_tx, bus.o_done, bus.o_busy, t, d, b);
            end
            if (i == 0) begin
                checks++;
                if (bus.o_txrdy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_txrdy_after_start: got %b want 1", name, bus.o_txrdy);
                end
            end
            if (bus.o_busy === 1'b1) busy_cnt++;
            drive_cfg(rand_cfg());
        end
        checks++;
        if (busy_cnt != ((exp_len > 0) ? exp_len : n - 2)) begin
            errors++;
            $display("FAIL %s_length: busy cycles=%0d want %0d", name, busy_cnt, (exp_len > 0) ? exp_len : n - 2);
        end
    endtask

    task automatic test_directed();
        test_frame("even_0x55", mk_cfg(8'h55, 4'd8, 1'b1, 2'd0, 1'b0, 16'd4), 44);
        test_frame("odd_0x83",  mk_cfg(8'h83, 4'd7, 1'b1, 2'd1, 1'b0, 16'd4), 40);
        test_frame("len5_2stop", mk_cfg(8'h1F, 4'd5, 1'b0, 2'd0, 1'b1, 16'd3), 24);
        test_frame("clamp_hi_mark", mk_cfg(8'hA6, 4'd15, 1'b1, 2'd2, 1'b1, 16'd1), 24);
        test_frame("clamp_lo_space", mk_cfg(8'hFF, 4'd2, 1'b1, 2'd3, 1'b0, 16'd0), 16);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            test_frame("random", rand_cfg(), 0);
        end
    endtask

    task automatic test_back_to_back();
        cfg_t a, b, z;
        int n;
        bit t, d, bz;
        a = rand_cfg(); b = rand_cfg(); z = rand_cfg();
        exp_tx.delete(); exp_done.delete(); exp_busy.delete();
        model_frame(a, 1'b0);
        model_frame(b, 1'b1);
        model_idle_tail();
        n = exp_tx.size();
        @(posedge clk); #1;
        drive_cfg(a); bus.i_load = 1'b1;
        @(posedge clk); #1;
        bus.i_load = 1'b0; drive_cfg(rand_cfg());
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t = exp_tx.pop_front(); d = exp_done.pop_front(); bz = exp_busy.pop_front();
            checks++;
            if (bus.o_tx !== t || bus.o_done !== d || bus.o_busy !== bz) begin
                errors++;
                $display("FAIL b2b_cycle%0d: tx=%b done=%b busy=%b want %b %b %b",
                         i, bus.o_tx, bus.o_done, bus.o_busy, t, d, bz);
            end
            case (i)
                1: begin
                    checks++;
                    if (bus.o_txrdy !== 1'b1) begin errors++; $display("FAIL b2b_txrdy_free: got %b want 1", bus.o_txrdy); end
                    drive_cfg(b); bus.i_load = 1'b1;
                end
                2: begin
                    bus.i_load = 1'b0;
                    checks++;
                    if (bus.o_txrdy !== 1'b0) begin errors++; $display("FAIL b2b_txrdy_full: got %b want 0", bus.o_txrdy); end
                    drive_cfg(rand_cfg());
                end
                3: begin drive_cfg(z); bus.i_load = 1'b1; end
                4: begin
                    bus.i_load = 1'b0;
                    checks++;
                    if (bus.o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.o_ovr); end
                end
                5: bus.i_clr_ovr = 1'b1;
                6: begin
                    bus.i_clr_ovr = 1'b0;
                    checks++;
                    if (bus.o_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus.o_ovr); end
                end
                7: begin bus.i_load = 1'b1; bus.i_clr_ovr = 1'b1; end
                8: begin
                    bus.i_load = 1'b0; bus.i_clr_ovr = 1'b0;
                    checks++;
                    if (bus.o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", bus.o_ovr); end
                end
                default: drive_cfg(rand_cfg());
            endcase
        end
    endtask

    task automatic test_reset_mid_frame();
        cfg_t c;
        c = mk_cfg(8'($urandom), 4'd8, 1'($urandom), 2'($urandom), 1'b0, 16'd4);
        @(posedge clk); #1;
        drive_cfg(c); bus.i_load = 1'b1;
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 16) begin
                checks++;
                if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", bus.o_busy); end
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_txrdy !== 1'b1 ||
            bus.o_done !== 1'b0 || bus.o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: tx=%b busy=%b txrdy=%b done=%b ovr=%b want 1 0 1 0 0",
                     bus.o_tx, bus.o_busy, bus.o_txrdy, bus.o_done, bus.o_ovr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_release%0d: done=%b tx=%b busy=%b want 0 1 0", i, bus.o_done, bus.o_tx, bus.o_busy);
            end
        end
        test_frame("after_abort", c, 40 + (c.pen ? 4 : 0));
    endtask

    // Main sequence
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/tx_frame_engine.md
TX_FRAME_ENGINE -- requirements
Module: tx_frame_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter BAUD_W, default 16, width of the bit-time divisor.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port LOAD  input  1  one-cycle strobe offering LOAD_DATA plus current configuration.
REQ-006 SHALL have port LOAD_DATA  input  DATA_W  character to send, LSB first.
REQ-007 SHALL have port LEN  input  4  data bits per frame.
REQ-008 SHALL have port PEN  input  1  parity enable.
REQ-009 SHALL have port PMODE  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-010 SHALL have port STOP2  input  1  1 = two stop bits, 0 = one.
REQ-011 SHALL have port BAUD_DIV  input  BAUD_W  clocks per bit.
REQ-012 SHALL have port CLR_OVR  input  1  clears OVR.
REQ-013 SHALL have port TX  output  1  serial line, idle high.
REQ-014 SHALL have port TXRDY  output  1  holding buffer empty; LOAD accepted.
REQ-015 SHALL have port BUSY  output  1  frame in progress (state not IDLE).
REQ-016 SHALL have port DONE  output  1  one-cycle pulse at end of each frame's last stop bit.
REQ-017 SHALL have port OVR  output  1  sticky overrun flag.

Function
REQ-018 SHALL provide a one-entry holding buffer capturing LOAD_DATA, LEN, PEN, PMODE, STOP2, BAUD_DIV on any edge where LOAD=1 and TXRDY=1; TXRDY falls on that edge.
REQ-019 SHALL ignore LOAD when TXRDY=0, leaving the buffer unchanged and setting OVR on that edge.
REQ-020 SHALL clear OVR on an edge with CLR_OVR=1 unless an overrun occurs on the same edge (set wins).
REQ-021 SHALL clamp LEN below 5 to 5 and above DATA_W to DATA_W at capture; BAUD_DIV below 2 SHALL be treated as 2.
REQ-022 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE with buffer full: next edge moves buffer to shift register, enters START, drives TX=0, raises TXRDY.
REQ-024 Each bit (start, data, parity, stop) SHALL hold TX constant for exactly BAUD_DIV clocks, counted by a down-counter reloaded at each bit boundary.
REQ-025 START -> DATA; DATA shifts out exactly LEN bits LSB first; bits above LEN ignored.
REQ-026 DATA -> PARITY if PEN=1, else STOP; PARITY -> STOP.
REQ-027 Parity bit SHALL be XOR of the LEN data bits (even), its inverse (odd), 1 (mark) or 0 (space).
REQ-028 STOP drives TX=1 for 1 or 2 bit times per STOP2.
REQ-029 At end of STOP: DONE=1 for one cycle; if buffer full, the same edge loads the next frame and enters START (no idle gap); else enters IDLE.
REQ-030 Configuration changes on inputs mid-frame SHALL NOT affect the frame in progress.
REQ-031 A LOAD accepted on the same edge the engine drains the buffer SHALL be impossible (TXRDY=0 that edge); it is ignored and flags OVR.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 RESET_N low SHALL immediately force TX=1, TXRDY=1, BUSY=0, DONE=0, OVR=0, state IDLE, buffer empty, counters 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no DONE pulse; first edge after release is IDLE.

Verification
REQ-035 BAUD_DIV=4, LEN=8, PEN=1, PMODE=00, STOP2=0, LOAD 0x55 -> TX 0,1,0,1,0,1,0,1,0,0,1 each 4 clocks (44 total), DONE once.
REQ-036 LEN=7, PEN=1, PMODE=01, LOAD 0x83 -> data 1,1,0,0,0,0,0, parity 1, one stop bit.
REQ-037 LEN=5, PEN=0, STOP2=1, BAUD_DIV=3, LOAD 0x1F -> 0,1,1,1,1,1,1,1; 24 clocks; BUSY high throughout.
REQ-038 Second LOAD during first frame (TXRDY=1) -> second start bit begins the edge DONE pulses; TX never idles between frames.
REQ-039 Third LOAD while TXRDY=0 -> ignored, OVR=1; CLR_OVR pulse -> OVR=0; simultaneous CLR_OVR and overrun -> OVR=1.
REQ-040 RESET_N low during DATA bit 3 -> TX=1, BUSY=0, TXRDY=1 immediately; no DONE; new LOAD after release sends full frame.
